pkt_rr_scheduler: RTL
=====================

Name: pkt_rr_scheduler

Overview:
- Round-robin scheduler that shares one Packetizer (16-bit HF/BF/TF in, 48-bit flit out, write_enable) among NUM_REQ requesters.
- Captures the winning requester's header/body/tail fields and presents them to the Packetizer with a load strobe.
- Waits for the Packetizer's write_enable, then acknowledges the requester.
- Gated by downstream FIFO full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FLIT_W, 16, width of each HF/BF/TF field.
- TIMEOUT, 16, WAIT_WR cycle limit; used only with PKT_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester packet request.
- req_hf  in  NUM_REQ*FLIT_W  packed header fields; requester i at [i*FLIT_W +: FLIT_W].
- req_bf  in  NUM_REQ*FLIT_W  packed body fields.
- req_tf  in  NUM_REQ*FLIT_W  packed tail fields.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- fifo_full  in  1  downstream flit FIFO full; blocks new grants.
- pz_hf  out  FLIT_W  HF to Packetizer.
- pz_bf  out  FLIT_W  BF to Packetizer.
- pz_tf  out  FLIT_W  TF to Packetizer.
- pz_load  out  1  one-cycle strobe: pz_* fields are valid and new.
- pz_wr_en  in  1  Packetizer write_enable: flit_out written.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee.
- busy  out  1  high when state != IDLE.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0; all outputs 0 (pz_*, pz_load, req_ack, grant_id, busy, timeout_err). Any in-flight transaction is dropped and no ack is issued; the requester must re-request.
- Arbitration: winner is the first asserted req_valid at index rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
- IDLE:
  - Grant when |req_valid and !fifo_full.
  - On the grant edge: register the winner's hf/bf/tf into pz_*; set grant_id; set pz_load=1 for exactly one cycle; go to WAIT_WR.
  - Latency: req_valid sampled at edge N gives pz_load high during cycle N+1.
  - If fifo_full=1: no grant; state stays IDLE.
- WAIT_WR:
  - pz_* and grant_id held stable; pz_load=0.
  - pz_wr_en=1 in the pz_load cycle itself is accepted.
  - On pz_wr_en=1: req_ack[grant_id]=1 next cycle; rr_ptr <= (grant_id+1) mod NUM_REQ; go to ACK.
  - fifo_full changes have no effect.
  - Requester dropping req_valid or changing its fields does not abort; the captured values are used and the ack still pulses.
- ACK:
  - req_ack pulses for one cycle; then return to IDLE.
  - req_valid is ignored in this cycle, so a requester has one cycle to deassert or present its next packet.
- pz_wr_en in IDLE or ACK is ignored.
- Peak throughput: one packet per 3 cycles (load, write, ack).
- Fairness: after NUM_REQ consecutive grants, every continuously requesting index has been served exactly once.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro: PKT_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_WR and increments each WAIT_WR cycle without pz_wr_en.
  - When the count reaches TIMEOUT: go to IDLE, no ack, rr_ptr advances past grant_id, timeout_err set.
  - timeout_err is sticky until reset.
- Not defined: WAIT_WR waits indefinitely; timeout_err is tied to 0; the port still exists.

Decomposition:
- Package pkt_sched_pkg:
  - FLIT_W=16, FLIT_OUT_W=48 (3*FLIT_W).
  - State typedef {IDLE, WAIT_WR, ACK}.
  - DEFAULT_NUM_REQ=4.
- Sub-module rr_arbiter: combinational rotate/priority pick; inputs req vector and rr_ptr; outputs any_req and winner index.
- The top level holds the FSM, capture registers, rr_ptr and the optional watchdog.

Test Plan:
- Single request: after reset release, req_valid=4'b0001 with hf=69, bf=44, tf=36; pz_wr_en asserted 1 cycle after pz_load -> pz_load one cycle with pz_hf=69/pz_bf=44/pz_tf=36, then req_ack=4'b0001 one cycle, grant_id=0, busy low afterwards.
- Round robin: req_valid=4'b1011 held, each grantee using its own values (11/12/13 for req0, 44/77/88 for req1, 1/2/3 for req3), pz_wr_en echoing pz_load -> grant order 0,1,3,0 and each ack matches its captured fields.
- Backpressure: fifo_full=1 with req_valid=4'b0100 for 5 cycles -> no pz_load, busy=0; fifo_full drops -> pz_load the next cycle, grant_id=2.
- Reset mid-operation: assert reset during WAIT_WR -> all outputs 0 immediately (asynchronous), no req_ack, rr_ptr=0.
- Field change after grant: req0 changes hf 69->11 during WAIT_WR -> pz_hf stays 69 until ack.
- PKT_SCHED_TIMEOUT_EN, TIMEOUT=16: grant with pz_wr_en never asserted -> after 16 WAIT_WR cycles, return to IDLE, timeout_err=1 (sticky), no req_ack; next grant goes to the next index.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packetizer round-robin scheduler.
package pkt_sched_pkg;

  localparam int unsigned FLIT_W          = 16;
  localparam int unsigned FLIT_OUT_W      = 3 * FLIT_W;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WR = 2'd1,
    ACK     = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first asserted request at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any_req_c,
  output logic [ID_W-1:0]    winner_c
);

  always_comb begin
    any_req_c = 1'b0;
    winner_c  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!any_req_c && req[ID_W'((32'(rr_ptr) + off) % NUM_REQ)]) begin
        any_req_c = 1'b1;
        winner_c  = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Round-robin scheduler sharing one Packetizer among NUM_REQ requesters.
// Optional WAIT_WR watchdog enabled by defining PKT_SCHED_TIMEOUT_EN.
module pkt_rr_scheduler #(
  parameter int unsigned NUM_REQ = pkt_sched_pkg::DEFAULT_NUM_REQ,
  parameter int unsigned FLIT_W  = pkt_sched_pkg::FLIT_W,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FLIT_W-1:0] req_hf,
  input  logic [NUM_REQ*FLIT_W-1:0] req_bf,
  input  logic [NUM_REQ*FLIT_W-1:0] req_tf,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      fifo_full,
  output logic [FLIT_W-1:0]         pz_hf,
  output logic [FLIT_W-1:0]         pz_bf,
  output logic [FLIT_W-1:0]         pz_tf,
  output logic                      pz_load,
  input  logic                      pz_wr_en,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  import pkt_sched_pkg::*;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("pkt_rr_scheduler: unsupported parameter set");
  end

  sched_state_e        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     winner_c;
  logic                any_req_c;
  logic                grant_c;
  logic                wd_expire_c;
  logic                pz_load_d;
  logic [NUM_REQ-1:0]  req_ack_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_req_c (any_req_c),
    .winner_c  (winner_c)
  );

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] id);
    return (32'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_c   = 1'b0;
    pz_load_d = 1'b0;
    req_ack_d = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req_c && !fifo_full) begin
          grant_c   = 1'b1;
          pz_load_d = 1'b1;
          state_d   = WAIT_WR;
        end
      end
      WAIT_WR: begin
        if (pz_wr_en) begin
          req_ack_d[grant_id] = 1'b1;
          rr_ptr_d            = next_idx(grant_id);
          state_d             = ACK;
        end else if (wd_expire_c) begin
          rr_ptr_d = next_idx(grant_id);
          state_d  = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, pointer and output strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      pz_hf    <= '0;
      pz_bf    <= '0;
      pz_tf    <= '0;
      pz_load  <= 1'b0;
      req_ack  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pz_load  <= pz_load_d;
      req_ack  <= req_ack_d;
      busy     <= (state_d != IDLE);
      if (grant_c) begin
        pz_hf    <= req_hf[32'(winner_c) * FLIT_W +: FLIT_W];
        pz_bf    <= req_bf[32'(winner_c) * FLIT_W +: FLIT_W];
        pz_tf    <= req_tf[32'(winner_c) * FLIT_W +: FLIT_W];
        grant_id <= winner_c;
      end
    end
  end

`ifdef PKT_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q;

  // Expire on the TIMEOUT-th WAIT_WR cycle without a write
  assign wd_expire_c = (state_q == WAIT_WR) && !pz_wr_en && (32'(wd_cnt_q) == TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_c)
        wd_cnt_q <= '0;
      else if (state_q == WAIT_WR && !pz_wr_en)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wd_expire_c)
        timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire_c = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
